// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles 32-bit words from four 1-byte memory reads.
// Define ICACHE_EN to add a 32-entry direct-mapped instruction cache in front of memory.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  issue_q, issue_d;
    logic [1:0]  recv_q, recv_d;
    logic [31:0] inst_q, inst_d;
    logic        gnt_q;
    logic        capture;

    // A byte is only accepted while a fetch is live; aborts and resets drop it.
    assign capture = gnt_q && !branch_flag_i && (state_q == StReq || state_q == StWait);

`ifdef ICACHE_EN
    logic [31:0] cache_data  [32];
    logic [24:0] cache_tag   [32];
    logic [31:0] cache_valid;
    logic [4:0]  cache_idx;
    logic        cache_hit;
    logic        cache_fill;

    assign cache_idx  = fetch_pc_q[6:2];
    assign cache_hit  = cache_valid[cache_idx] && (cache_tag[cache_idx] == fetch_pc_q[31:7]);
    assign cache_fill = (state_q == StWait) && capture && (recv_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= '0;
        end else if (cache_fill) begin
            cache_valid[cache_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cache_fill) begin
            cache_data[cache_idx] <= {mem_din_i, inst_q[23:0]};
            cache_tag[cache_idx]  <= fetch_pc_q[31:7];
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_d      = issue_q;
        recv_d       = recv_q;
        inst_d       = inst_q;
        mem_req_o    = 1'b0;
        mem_addr_o   = 32'd0;
        inst_valid_o = 1'b0;

        if (capture) begin
            inst_d[{recv_q, 3'b000} +: 8] = mem_din_i;
            recv_d = recv_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!stall_i) begin
`ifdef ICACHE_EN
                    if (cache_hit) begin
                        state_d = StDone;
                        inst_d  = cache_data[cache_idx];
                    end else
`endif
                    begin
                        state_d = StReq;
                        issue_d = 2'd0;
                        recv_d  = 2'd0;
                    end
                end
            end
            StReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = fetch_pc_q + {30'd0, issue_q};
                if (mem_gnt_i) begin
                    issue_d = issue_q + 2'd1;
                    if (issue_q == 2'd3) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (capture && recv_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!stall_i) begin
                    inst_valid_o = 1'b1;
                    fetch_pc_d   = fetch_pc_q + 32'd4;
                    state_d      = StIdle;
                end
            end
        endcase

        // Redirect overrides everything, including a delivery in the same cycle.
        if (branch_flag_i) begin
            state_d      = StIdle;
            fetch_pc_d   = branch_target_i;
            issue_d      = 2'd0;
            recv_d       = 2'd0;
            inst_d       = 32'd0;
            mem_req_o    = 1'b0;
            inst_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= 32'd0;
            issue_q    <= 2'd0;
            recv_q     <= 2'd0;
            inst_q     <= 32'd0;
            gnt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            issue_q    <= issue_d;
            recv_q     <= recv_d;
            inst_q     <= inst_d;
            gnt_q      <= mem_req_o && mem_gnt_i;
        end
    end

    assign pc_o   = fetch_pc_q;
    assign inst_o = inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte-serving memory, transaction-level model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_din_i = 8'hEE;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_din_i      (mem_din_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Low memory holds li a0,10 / li a1,1 / li a2,11 / li a3,12; the rest is a hash.
    logic [7:0] rom [16] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
                             8'h13, 8'h06, 8'hB0, 8'h00, 8'h93, 8'h06, 8'hC0, 8'h00};

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'd16) return rom[a[3:0]];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory: a granted byte read returns its data during the following cycle.
    logic        pend_g = 1'b0;
    logic [31:0] pend_a = 32'd0;
    always @(negedge clk) begin
        mem_din_i <= pend_g ? mem_byte(pend_a) : 8'hEE;
        pend_g    <= mem_req_o && mem_gnt_i;
        pend_a    <= mem_addr_o;
    end

    // Model: words are delivered in program order from the current pc, built from
    // bytes requested at pc+0..pc+3; a redirect restarts at the target.
    logic [31:0] exp_pc  = 32'd0;
    int          exp_off = 0;
    always @(negedge clk) begin
        if (rst) begin
            exp_pc  = 32'd0;
            exp_off = 0;
        end else if (branch_flag_i) begin
            chk("m_branch_req", {31'd0, mem_req_o}, 32'd0);
            chk("m_branch_valid", {31'd0, inst_valid_o}, 32'd0);
            exp_pc  = branch_target_i;
            exp_off = 0;
        end else begin
            if (mem_req_o) begin
                chk("m_issue_bound", {31'd0, exp_off < 4}, 32'd1);
                chk("m_addr", mem_addr_o, exp_pc + exp_off);
                if (mem_gnt_i) exp_off++;
            end
            if (inst_valid_o) begin
                chk("m_valid_stall", {31'd0, stall_i}, 32'd0);
                chk("m_pc", pc_o, exp_pc);
                chk("m_inst", inst_o, mem_word(exp_pc));
                exp_pc  = exp_pc + 32'd4;
                exp_off = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one fetch from the current cycle; schedule is relative to the first request.
    task automatic fetch(input logic [31:0] base, input int hold, input int st_lo,
                         input int st_hi, input int br_at, input logic [31:0] br_tgt,
                         input bit hit_ok, output int lat);
        int first, grants, rel;
        logic [31:0] held;
        bit done;
        first  = -1;
        grants = 0;
        lat    = -1;
        held   = 32'd0;
        done   = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            branch_flag_i = 1'b0;
            #1;
            if (mem_req_o && first < 0) first = cyc;
            rel = (first < 0) ? -1 : cyc - first;
            mem_gnt_i = !(grants == 2 && hold > 0);
            if (!mem_gnt_i) hold--;
            stall_i         = (rel >= st_lo && rel <= st_hi);
            branch_flag_i   = (first >= 0 && rel == br_at);
            branch_target_i = br_tgt;
            #1;
            if (branch_flag_i) begin
                chk("abort_req", {31'd0, mem_req_o}, 32'd0);
                chk("abort_valid", {31'd0, inst_valid_o}, 32'd0);
                tick();
                branch_flag_i = 1'b0;
                done = 1'b1;
            end else begin
                if (mem_req_o) begin
                    chk("fetch_addr", mem_addr_o, base + grants);
                    if (mem_gnt_i) grants++;
                end
                if (stall_i && rel >= 5) begin
                    chk("stall_valid", {31'd0, inst_valid_o}, 32'd0);
                    chk("stall_req", {31'd0, mem_req_o}, 32'd0);
                    if (rel == 5) held = inst_o;
                    else chk("stall_hold", inst_o, held);
                end
                if (inst_valid_o) begin
                    if (first < 0 && !hit_ok) fail_now("valid_without_request");
                    lat  = (first < 0) ? -1 : cyc - first;
                    done = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        if (!done) fail_now("fetch_timeout");
        stall_i   = 1'b0;
        mem_gnt_i = 1'b1;
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        branch_flag_i   = 1'b1;
        branch_target_i = tgt;
        #1;
        chk("br_req", {31'd0, mem_req_o}, 32'd0);
        chk("br_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        branch_flag_i = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;
        mem_gnt_i       = 1'b1;
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b0;

        // Plain fetch at 0: addresses 0..3 back to back, word after 5 cycles.
        fetch(32'd0, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t1_latency", lat, 32'd5);
        chk("t1_inst", inst_o, 32'h00A00513);
        chk("t1_pc", pc_o, 32'd0);
        tick();

        // Same word again after reset, with three grant-less cycles after byte 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch(32'd0, 3, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t2_latency", lat, 32'd8);
        chk("t2_inst", inst_o, 32'h00A00513);
        tick();

        // Stall held through four DONE cycles, then one delivery and the next fetch at +4.
        fetch(32'd4, 0, 1, 8, -99, 32'd0, 1'b0, lat);
        chk("t3_latency", lat, 32'd9);
        chk("t3_inst", inst_o, 32'h00100593);
        chk("t3_pc", pc_o, 32'd4);
        tick();
        fetch(32'd8, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t3_next_latency", lat, 32'd5);
        chk("t3_next_inst", inst_o, 32'h00B00613);
        tick();

        // Redirect while byte 2 is being requested.
        fetch(32'd12, 0, 99, -1, 2, 32'h0000_1000, 1'b0, lat);
        fetch(32'h0000_1000, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t4_latency", lat, 32'd5);
        chk("t4_inst", inst_o, 32'h4948_4B4A);
        chk("t4_pc", pc_o, 32'h0000_1000);
        tick();

        // Redirect in the cycle the word would be delivered.
        fetch(32'h0000_1004, 0, 99, -1, 5, 32'h0000_0020, 1'b0, lat);
        fetch(32'h0000_0020, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t5_inst", inst_o, 32'h7978_7B7A);
        chk("t5_pc", pc_o, 32'h0000_0020);
        tick();

        // Top of the address space, then wrap to 0.
        do_branch(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t6_inst", inst_o, 32'h5A5B_5859);
        chk("t6_pc", pc_o, 32'hFFFF_FFFC);
        tick();
        fetch(32'd0, 0, 99, -1, -99, 32'd0, 1'b1, lat);
        chk("t6_wrap_pc", pc_o, 32'd0);
        chk("t6_wrap_inst", inst_o, 32'h00A00513);
        tick();

        // Reset in the middle of a fetch; the returning byte must not leak in.
        do_branch(32'h0000_0100);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (mem_req_o && mem_addr_o == 32'h0000_0102) found = 1'b1;
            else tick();
        end
        if (!found) fail_now("t7_no_request");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        fetch(32'd0, 0, 99, -1, -99, 32'd0, 1'b0, lat);
        chk("t7_latency", lat, 32'd5);
        chk("t7_inst", inst_o, 32'h00A00513);
        tick();

`ifdef ICACHE_EN
        // Branch back to 0: hit, no memory traffic, word one cycle after IDLE.
        do_branch(32'd0);
        chk("t8_idle_req", {31'd0, mem_req_o}, 32'd0);
        chk("t8_idle_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        chk("t8_hit_req", {31'd0, mem_req_o}, 32'd0);
        chk("t8_hit_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t8_hit_pc", pc_o, 32'd0);
        chk("t8_hit_inst", inst_o, 32'h00A00513);
        tick();
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
